// File: rtl/shreg_ctrl_pkg.sv
// Shared definitions for the display shift-register sequencer:
// FSM state encoding and requester indices.
package shreg_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/shreg_ctrl_if.sv
// Request bundle for the two requesters feeding shreg_ctrl.
// The requesters drive through master; the sequencer grants through slave.
interface shreg_req_if #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5
);
    logic [1:0]       i_req_valid;
    logic [1:0]       o_req_ready;
    logic [WIDTH-1:0] i_req_data0;
    logic [WIDTH-1:0] i_req_data1;
    logic [LEN_W-1:0] i_req_len0;
    logic [LEN_W-1:0] i_req_len1;

    modport master (
        output i_req_valid, i_req_data0, i_req_data1, i_req_len0, i_req_len1,
        input  o_req_ready
    );

    modport slave (
        input  i_req_valid, i_req_data0, i_req_data1, i_req_len0, i_req_len1,
        output o_req_ready
    );
endinterface

// File: rtl/shreg_ctrl_tick_gen.sv
// Programmable terminal-count divider: counts 0..DIV-1 while enabled and
// pulses tick on the terminal count; synchronous clear has priority over enable.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick = en && (cnt_q == TERM);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/shreg_ctrl.sv
// Round-robin arbiter and load/shift sequencer for the display shift register:
// one parallel load, then N shift pulses spaced TICK_DIV cycles, then done.
module shreg_ctrl
    import shreg_ctrl_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int TICK_DIV = 25_000_000,
    parameter int LEN_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    shreg_req_if.slave       req,
    input  logic             i_fill_bit,
    input  logic             i_abort,
    output logic [WIDTH-1:0] o_wr_data,
    output logic             o_wr_data_en,
    output logic             o_shift_en,
    output logic             o_wr_bit,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_aborted,
    output logic             o_owner
);
    localparam logic [LEN_W-1:0] WIDTH_LEN = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

    state_t           state_q, next_state;
    logic [WIDTH-1:0] data_q, wr_hold_q;
    logic [LEN_W-1:0] len_q;
    logic             owner_q, rr_ptr_q, aborted_q;

    logic [1:0]       grant;
    logic             accept, grant_idx, tick;
    logic [WIDTH-1:0] sel_data;
    logic [LEN_W-1:0] sel_len, clamped_len;

    // Arbiter: only idle accepts; on contention the pointer picks the winner.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = 2'b00;
        if (state_q == ST_IDLE) begin
            if (&req.i_req_valid)
                grant = (rr_ptr_q == REQ1) ? 2'b10 : 2'b01;
            else
                grant = req.i_req_valid;
        end
    end

    assign req.o_req_ready = grant;
    assign accept          = |grant;
    assign grant_idx       = grant[1] ? REQ1 : REQ0;
    assign sel_data        = (grant_idx == REQ1) ? req.i_req_data1 : req.i_req_data0;
    assign sel_len         = (grant_idx == REQ1) ? req.i_req_len1 : req.i_req_len0;
    assign clamped_len     = (sel_len > WIDTH_LEN) ? WIDTH_LEN : sel_len;

    tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q == ST_LOAD),
        .en   (state_q == ST_SHIFT),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= next_state;
    end

    always_comb begin
        next_state = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept) next_state = ST_LOAD;
            ST_LOAD:  next_state = (i_abort || len_q == '0) ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (i_abort || (tick && len_q == LEN_ONE)) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // NOTE: the word/length holding registers are reset too, because the
    // outputs they feed (o_wr_data, o_owner) must read 0 straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q    <= '0;
            wr_hold_q <= '0;
            len_q     <= '0;
            owner_q   <= REQ0;
            rr_ptr_q  <= REQ0;
            aborted_q <= 1'b0;
        end else begin
            if (accept) begin
                data_q    <= sel_data;
                len_q     <= clamped_len;
                owner_q   <= grant_idx;
                aborted_q <= 1'b0;
            end
            if (state_q == ST_LOAD)
                wr_hold_q <= data_q;
            if (state_q == ST_SHIFT && tick)
                len_q <= len_q - 1'b1;
            if ((state_q == ST_LOAD || state_q == ST_SHIFT) && i_abort)
                aborted_q <= 1'b1;
            if (state_q == ST_DONE)
                rr_ptr_q <= ~owner_q;
        end
    end

    // Strobes decode from the state register, so an asynchronous reset
    // drops them immediately.
    always_comb begin
        o_wr_data_en = (state_q == ST_LOAD);
        o_wr_data    = (state_q == ST_LOAD) ? data_q : wr_hold_q;
        o_shift_en   = (state_q == ST_SHIFT) && tick;
        o_wr_bit     = (state_q == ST_SHIFT) && tick && i_fill_bit;
        o_busy       = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
        o_done       = (state_q == ST_DONE);
        o_aborted    = (state_q == ST_DONE) && aborted_q;
    end

    assign o_owner = owner_q;
endmodule
